// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the data port.
// Data has priority; a streak counter forces fetch through, and a timeout aborts stuck requests.
module mem_port_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ready,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        m_valid,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_size,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        owner,
    output logic        err
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_streak, w_streak_nxt;
    logic [TW-1:0] r_tcnt, w_tcnt_nxt;
    logic          r_m_valid, w_m_valid_nxt;
    logic          r_m_rw, w_m_rw_nxt;
    logic [31:0]   r_m_addr, w_m_addr_nxt;
    logic [31:0]   r_m_wdata, w_m_wdata_nxt;
    logic [1:0]    r_m_size, w_m_size_nxt;
    logic          r_f_ready, w_f_ready_nxt;
    logic          r_d_ready, w_d_ready_nxt;
    logic [31:0]   r_f_rdata, w_f_rdata_nxt;
    logic [31:0]   r_d_rdata, w_d_rdata_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_err, w_err_nxt;

    // A port whose ready pulse is showing is still holding its old request; keep it out of this grant.
    logic w_f_elig, w_d_elig, w_grant_d, w_grant_f;
    assign w_f_elig  = f_req & ~r_f_ready;
    assign w_d_elig  = d_req & ~r_d_ready;
    assign w_grant_d = w_d_elig & ~(w_f_elig & (r_streak == STREAK_MAX));
    assign w_grant_f = w_f_elig & ~w_grant_d;

    always_comb begin
        w_state_nxt   = r_state;
        w_streak_nxt  = r_streak;
        w_tcnt_nxt    = r_tcnt;
        w_m_valid_nxt = r_m_valid;
        w_m_rw_nxt    = r_m_rw;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_m_size_nxt  = r_m_size;
        w_f_ready_nxt = 1'b0;
        w_d_ready_nxt = 1'b0;
        w_f_rdata_nxt = r_f_rdata;
        w_d_rdata_nxt = r_d_rdata;
        w_owner_nxt   = r_owner;
        w_err_nxt     = r_err;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt   = BUSY_D;
                    w_m_valid_nxt = 1'b1;
                    w_m_rw_nxt    = d_rw;
                    w_m_addr_nxt  = d_addr;
                    w_m_wdata_nxt = d_wdata;
                    w_m_size_nxt  = d_size;
                    w_owner_nxt   = 1'b1;
                    w_tcnt_nxt    = '0;
                    if (!f_req)
                        w_streak_nxt = '0;
                    else if (r_streak != STREAK_MAX)
                        w_streak_nxt = r_streak + SW'(1);
                end else if (w_grant_f) begin
                    w_state_nxt   = BUSY_F;
                    w_m_valid_nxt = 1'b1;
                    w_m_rw_nxt    = 1'b0;
                    w_m_addr_nxt  = f_addr;
                    w_m_wdata_nxt = '0;
                    w_m_size_nxt  = 2'd2;
                    w_owner_nxt   = 1'b0;
                    w_tcnt_nxt    = '0;
                    w_streak_nxt  = '0;
                end
            end
            BUSY_F, BUSY_D: begin
                // An ack arriving on the expiry cycle wins over the abort.
                if (m_ack || (r_tcnt == TCNT_LAST)) begin
                    w_state_nxt   = IDLE;
                    w_m_valid_nxt = 1'b0;
                    w_tcnt_nxt    = '0;
                    if (r_state == BUSY_F) w_f_ready_nxt = 1'b1;
                    else                   w_d_ready_nxt = 1'b1;
                    if (!m_ack) begin
                        w_err_nxt = 1'b1;
                        if (r_state == BUSY_F) w_f_rdata_nxt = '0;
                        else                   w_d_rdata_nxt = '0;
                    end else if (r_state == BUSY_F) begin
                        w_f_rdata_nxt = m_rdata;
                    end else if (!r_m_rw) begin
                        w_d_rdata_nxt = m_rdata;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + TW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_streak  <= '0;
            r_tcnt    <= '0;
            r_m_valid <= 1'b0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_size  <= '0;
            r_f_ready <= 1'b0;
            r_d_ready <= 1'b0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
            r_owner   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_streak  <= w_streak_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_m_rw    <= w_m_rw_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_m_size  <= w_m_size_nxt;
            r_f_ready <= w_f_ready_nxt;
            r_d_ready <= w_d_ready_nxt;
            r_f_rdata <= w_f_rdata_nxt;
            r_d_rdata <= w_d_rdata_nxt;
            r_owner   <= w_owner_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign busy    = (r_state != IDLE);
    assign owner   = r_owner;
    assign err     = r_err;
    assign m_valid = r_m_valid;
    assign m_rw    = r_m_rw;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign m_size  = r_m_size;
    assign f_ready = r_f_ready;
    assign d_ready = r_d_ready;
    assign f_rdata = r_f_rdata;
    assign d_rdata = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, directed scenarios, random traffic.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;
    localparam int TMO  = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_rw, m_ack;
    logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
    logic [1:0]  d_size;
    logic        f_ready, d_ready, m_valid, m_rw, busy, owner, err;
    logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
    logic [1:0]  m_size;

    mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .busy(busy), .owner(owner), .err(err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Reference model: one transaction in flight at most, described by its fields and its age.
    bit          mdl_busy;
    bit          cur_port;
    bit          cur_rw;
    logic [31:0] cur_addr, cur_wdata;
    logic [1:0]  cur_size;
    int          mdl_age, mdl_streak;
    logic        exp_f_ready, exp_d_ready, exp_err;
    logic [31:0] exp_f_rdata, exp_d_rdata;

    task automatic model_reset();
        mdl_busy = 0; cur_port = 0; cur_rw = 0; cur_addr = 0; cur_wdata = 0; cur_size = 0;
        mdl_age = 0; mdl_streak = 0;
        exp_f_ready = 0; exp_d_ready = 0; exp_err = 0; exp_f_rdata = 0; exp_d_rdata = 0;
    endtask

    task automatic model_finish(input bit aborted, input logic [31:0] data);
        mdl_busy = 0;
        if (aborted) exp_err = 1;
        if (cur_port == 0) begin
            exp_f_ready = 1;
            exp_f_rdata = aborted ? 32'd0 : data;
        end else begin
            exp_d_ready = 1;
            if (aborted)      exp_d_rdata = 32'd0;
            else if (!cur_rw) exp_d_rdata = data;
        end
    endtask

    task automatic model_step();
        bit fe, de;
        fe = f_req && !exp_f_ready;
        de = d_req && !exp_d_ready;
        exp_f_ready = 0;
        exp_d_ready = 0;
        if (!mdl_busy) begin
            if (de && !(fe && mdl_streak >= MAXS)) begin
                cur_port = 1; cur_rw = d_rw; cur_addr = d_addr; cur_wdata = d_wdata; cur_size = d_size;
                mdl_streak = f_req ? ((mdl_streak + 1 > MAXS) ? MAXS : mdl_streak + 1) : 0;
                mdl_busy = 1; mdl_age = 0;
            end else if (fe) begin
                cur_port = 0; cur_rw = 0; cur_addr = f_addr; cur_wdata = 0; cur_size = 2;
                mdl_streak = 0;
                mdl_busy = 1; mdl_age = 0;
            end
        end else if (m_ack) begin
            model_finish(0, m_rdata);
        end else if (mdl_age == TMO - 1) begin
            model_finish(1, 32'd0);
        end else begin
            mdl_age++;
        end
    endtask

    bit chk_en = 0;
    always @(negedge clock) begin
        if (chk_en) begin
            chk1("m_valid", m_valid, mdl_busy);
            chk1("busy", busy, mdl_busy);
            chk1("f_ready", f_ready, exp_f_ready);
            chk1("d_ready", d_ready, exp_d_ready);
            chk("f_rdata", f_rdata, exp_f_rdata);
            chk("d_rdata", d_rdata, exp_d_rdata);
            chk1("err", err, exp_err);
            chk1("dual_ready", f_ready & d_ready, 1'b0);
            if (mdl_busy) begin
                chk1("owner", owner, cur_port);
                chk1("m_rw", m_rw, cur_rw);
                chk("m_addr", m_addr, cur_addr);
                chk("m_wdata", m_wdata, cur_wdata);
                chk("m_size", {30'd0, m_size}, {30'd0, cur_size});
            end
        end
    end

    // Memory responder: fixed latency (>=0), never (-1) or random (-2, with stray acks while idle).
    int          mem_lat = 0;
    int          wcnt = 0;
    logic [31:0] mem_val = 0;
    bit          prev_busy = 0;
    int          dut_log[$];

    task automatic mem_drive();
        m_ack = 0;
        if (m_valid) begin
            if (mem_lat == -2) begin
                if ($urandom_range(0, 2) == 0) begin m_ack = 1; m_rdata = $urandom; end
            end else if (mem_lat >= 0 && wcnt == mem_lat) begin
                m_ack = 1; m_rdata = mem_val; wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (mem_lat == -2 && $urandom_range(0, 3) == 0) begin m_ack = 1; m_rdata = $urandom; end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset) model_step();
        @(negedge clock);
        mem_drive();
        if (busy && !prev_busy) dut_log.push_back(int'(owner));
        prev_busy = busy;
    endtask

    task automatic do_txn(input bit port, input bit rw, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input int lat, input logic [31:0] val,
                          output int lat_cyc, output int vcyc, output logic [31:0] cap_addr,
                          output logic [31:0] cap_wdata, output logic [1:0] cap_size, output logic cap_rw);
        bit done;
        mem_lat = lat; mem_val = val;
        if (port) begin d_req = 1; d_rw = rw; d_addr = addr; d_wdata = wdata; d_size = size; end
        else begin f_req = 1; f_addr = addr; end
        lat_cyc = 0; vcyc = 0; done = 0;
        cap_addr = 0; cap_wdata = 0; cap_size = 0; cap_rw = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            lat_cyc++;
            if (m_valid) begin
                if (vcyc == 0) begin cap_addr = m_addr; cap_wdata = m_wdata; cap_size = m_size; cap_rw = m_rw; end
                vcyc++;
            end
            if (port ? d_ready : f_ready) done = 1;
        end
        chk1("txn_done", port ? d_ready : f_ready, 1'b1);
        if (port) d_req = 0; else f_req = 0;
    endtask

    task automatic client_random();
        if (f_req && f_ready) begin f_req = 1'($urandom_range(0, 1)); f_addr = $urandom; end
        else if (!f_req && $urandom_range(0, 3) == 0) begin f_req = 1; f_addr = $urandom; end
        else if (f_req && busy && !owner && $urandom_range(0, 3) == 0) f_addr = $urandom;
        if (d_req && d_ready) begin
            d_req = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            d_rw = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        end else if (!d_req && $urandom_range(0, 3) == 0) begin
            d_req = 1; d_addr = $urandom; d_wdata = $urandom;
            d_rw = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
        end else if (d_req && busy && owner && $urandom_range(0, 3) == 0) begin
            d_addr = $urandom; d_wdata = $urandom; d_rw = ~d_rw;
        end
    endtask

    initial begin
        int          lc, vc, both;
        logic [31:0] ca, cw;
        logic [1:0]  cs;
        logic        cr;

        reset = 0; f_req = 0; f_addr = 0; d_req = 0; d_rw = 0; d_addr = 0; d_wdata = 0; d_size = 0;
        m_ack = 0; m_rdata = 0;
        model_reset();
        tick(); tick();
        chk1("rst_m_valid", m_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_f_rdata", f_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk1("rst_f_ready", f_ready, 1'b0);
        reset = 1;
        chk_en = 1;

        do_txn(0, 0, 32'h0100_0000, 32'd0, 2'd0, 0, 32'h0050_0093, lc, vc, ca, cw, cs, cr);
        chk("fetch_latency", lc, 2);
        chk("fetch_valid_cycles", vc, 1);
        chk("fetch_m_addr", ca, 32'h0100_0000);
        chk("fetch_m_size", {30'd0, cs}, 32'd2);
        chk1("fetch_m_rw", cr, 1'b0);
        chk("fetch_rdata", f_rdata, 32'h0050_0093);
        tick();
        chk1("fetch_ready_once", f_ready, 1'b0);
        chk("model_fetch_rdata", exp_f_rdata, 32'h0050_0093);

        do_txn(1, 0, 32'h0100_0200, 32'd0, 2'd2, 1, 32'h1122_3344, lc, vc, ca, cw, cs, cr);
        chk("load_latency", lc, 3);
        chk("load_rdata", d_rdata, 32'h1122_3344);
        tick();

        do_txn(1, 1, 32'h0100_0100, 32'hCAFE_F00D, 2'd0, 3, 32'hDEAD_BEEF, lc, vc, ca, cw, cs, cr);
        chk("store_valid_cycles", vc, 4);
        chk("store_latency", lc, 5);
        chk("store_m_addr", ca, 32'h0100_0100);
        chk("store_m_wdata", cw, 32'hCAFE_F00D);
        chk("store_m_size", {30'd0, cs}, 32'd0);
        chk1("store_m_rw", cr, 1'b1);
        chk("store_keeps_rdata", d_rdata, 32'h1122_3344);
        tick();
        chk1("store_ready_once", d_ready, 1'b0);

        do_txn(1, 0, 32'h0100_0300, 32'd0, 2'd2, -1, 32'd0, lc, vc, ca, cw, cs, cr);
        chk("timeout_busy_cycles", vc, 64);
        chk("timeout_rdata", d_rdata, 32'd0);
        chk1("timeout_err", err, 1'b1);
        tick();
        do_txn(0, 0, 32'h0100_0004, 32'd0, 2'd0, 2, 32'h0000_0013, lc, vc, ca, cw, cs, cr);
        chk("post_timeout_latency", lc, 4);
        chk1("err_sticky", err, 1'b1);
        chk("model_err_pin", {31'd0, exp_err}, 32'd1);

        // Reset while a fetch is outstanding.
        tick();
        f_req = 1; f_addr = 32'h0100_0040; mem_lat = -1;
        tick(); tick();
        chk1("pre_reset_busy", busy, 1'b1);
        #2;
        reset = 0; f_req = 0;
        model_reset();
        #1;
        chk1("async_rst_m_valid", m_valid, 1'b0);
        chk1("async_rst_busy", busy, 1'b0);
        tick();
        chk1("rst_no_f_ready", f_ready, 1'b0);
        chk1("rst_clears_err", err, 1'b0);
        reset = 1;
        do_txn(0, 0, 32'h0100_0044, 32'd0, 2'd0, 0, 32'h00A0_0113, lc, vc, ca, cw, cs, cr);
        chk("after_reset_latency", lc, 2);
        chk("after_reset_rdata", f_rdata, 32'h00A0_0113);

        // Both ports requesting from reset with a one-cycle memory.
        tick();
        #2;
        reset = 0;
        model_reset();
        f_req = 1; f_addr = 32'h0100_1000;
        d_req = 1; d_rw = 0; d_addr = 32'h0200_0000; d_size = 2;
        mem_lat = 0; mem_val = 32'h5555_AAAA;
        tick();
        reset = 1;
        dut_log.delete();
        both = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (f_ready && d_ready) both++;
            if (d_ready) d_addr = d_addr + 32'd4;
            if (f_ready) f_addr = f_addr + 32'd4;
        end
        chk1("sim_grants_logged", dut_log.size() >= 8, 1'b1);
        for (int i = 0; i < 8 && i < dut_log.size(); i++)
            chk($sformatf("sim_owner_%0d", i), dut_log[i], (i % 2 == 0) ? 32'd1 : 32'd0);
        chk("sim_no_dual_ready", both, 0);

        // Random traffic with random memory timing and attribute changes during service.
        mem_lat = -2;
        for (int i = 0; i < 3000; i++) begin
            tick();
            client_random();
        end
        f_req = 0; d_req = 0;
        for (int i = 0; i < 200 && (busy || f_ready || d_ready); i++) tick();
        chk1("drain_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
